pipelined_processor_param: RTL and testbench

- Parametrised successor to the fixed 8-bit pipelined processor.
- Generalised data width, register count and PC width. Instructions come from an external instruction-memory port.
- Adds three features: WB-to-EX operand forwarding, a HALT instruction, and a run_en pipeline freeze.
- Sits at the top of the processor hierarchy. Benches drive clk/reset and observe instr and rVal.

---
 rtl/pp_pkg.sv | 38 +++
 rtl/pp_regfile.sv | 35 +++
 rtl/pipelined_processor_param.sv | 127 ++++++++++++
 tb/tb_pipelined_processor_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared opcode encoding, instruction field helpers and pipeline control types
// for the parametrised pipelined processor.
package pp_pkg;

    // Widest instruction the field helpers accept; narrower words are zero-extended.
    localparam int PP_MAX_INSTR_W = 64;

    typedef logic [PP_MAX_INSTR_W-1:0] instr_wide_t;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_ADD  = 2'b01,
        OP_LDI  = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef struct packed {
        logic valid;
        logic wr;
    } wb_ctrl_t;

    function automatic opcode_e instr_op(input instr_wide_t ins, input int instrW);
        return opcode_e'(ins[instrW-2 +: 2]);
    endfunction

    function automatic instr_wide_t instr_rd(input instr_wide_t ins, input int raW);
        instr_wide_t mask;
        mask = (instr_wide_t'(1) << raW) - instr_wide_t'(1);
        return (ins >> raW) & mask;
    endfunction

    function automatic instr_wide_t instr_rs(input instr_wide_t ins, input int raW);
        instr_wide_t mask;
        mask = (instr_wide_t'(1) << raW) - instr_wide_t'(1);
        return ins & mask;
    endfunction

endpackage

// File: rtl/pp_regfile.sv
// Register file: 2^RA_W registers that reset to their own index, two
// combinational read ports and one synchronous write port.
module pp_regfile #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   raddr_a_i,
    input  logic [RA_W-1:0]   raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NREG = 1 << RA_W;

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/pipelined_processor_param.sv
// Three-stage (IF, EX, WB) parametrised processor with WB-to-EX forwarding,
// a sticky HALT and a global run_en freeze.
module pipelined_processor_param
    import pp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RA_W    = 3,
    parameter int INSTR_W = 2 + 2 * RA_W,
    parameter int PC_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  rVal,
    output logic               halted
);

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] ins;
    } ifid_t;

    typedef struct packed {
        wb_ctrl_t           ctrl;
        logic [RA_W-1:0]    rd;
        logic [DATA_W-1:0]  result;
    } exwb_t;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              halted_q, halted_d;
    ifid_t             ifid_q, ifid_d;
    exwb_t             exwb_q, exwb_d;

    opcode_e           fetchOp, exOp;
    logic [RA_W-1:0]   exRd, exRs;
    logic signed [RA_W-1:0] exRsSigned;
    logic [DATA_W-1:0] rfRd, rfRs, opRd, opRs;
    logic              wbWrite;

    assign fetchOp    = instr_op(instr_wide_t'(imem_data), INSTR_W);
    assign exOp       = instr_op(instr_wide_t'(ifid_q.ins), INSTR_W);
    assign exRd       = RA_W'(instr_rd(instr_wide_t'(ifid_q.ins), RA_W));
    assign exRs       = RA_W'(instr_rs(instr_wide_t'(ifid_q.ins), RA_W));
    assign exRsSigned = exRs;
    assign wbWrite    = exwb_q.ctrl.valid && exwb_q.ctrl.wr;

    pp_regfile #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (run_en && wbWrite),
        .waddr_i   (exwb_q.rd),
        .wdata_i   (exwb_q.result),
        .raddr_a_i (exRd),
        .raddr_b_i (exRs),
        .rdata_a_o (rfRd),
        .rdata_b_o (rfRs)
    );

    // The result still in EX/WB is newer than the register file copy.
    always_comb begin
        opRd = rfRd;
        opRs = rfRs;
        if (wbWrite && exwb_q.rd == exRd) opRd = exwb_q.result;
        if (wbWrite && exwb_q.rd == exRs) opRs = exwb_q.result;
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ifid_d   = '0;
        if (!halted_q) begin
            ifid_d.valid = 1'b1;
            ifid_d.ins   = imem_data;
            if (fetchOp == OP_HALT) halted_d = 1'b1;
            else                    pc_d     = pc_q + PC_W'(1);
        end

        exwb_d = '0;
        if (ifid_q.valid) begin
            exwb_d.ctrl.valid = 1'b1;
            exwb_d.rd         = exRd;
            case (exOp)
                OP_MOV: begin
                    exwb_d.ctrl.wr = 1'b1;
                    exwb_d.result  = opRs;
                end
                OP_ADD: begin
                    exwb_d.ctrl.wr = 1'b1;
                    exwb_d.result  = opRd + opRs;
                end
                OP_LDI: begin
                    exwb_d.ctrl.wr = 1'b1;
                    exwb_d.result  = DATA_W'(exRsSigned);
                end
                OP_HALT: begin
                    exwb_d.ctrl.wr = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            ifid_q   <= '0;
            exwb_q   <= '0;
        end else if (run_en) begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ifid_q   <= ifid_d;
            exwb_q   <= exwb_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = ifid_q.ins;
    assign rVal      = exwb_q.result;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pipelined_processor_param.sv
// Directed bench for pipelined_processor_param at default parameters,
// with hand-computed expectations checked by immediate assertions.
module tb_pipelined_processor_param;

    localparam int DATA_W  = 8;
    localparam int RA_W    = 3;
    localparam int INSTR_W = 8;
    localparam int PC_W    = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               run_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  rVal;
    logic               halted;

    logic [7:0] imem [16];
    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    pipelined_processor_param #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .PC_W   (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .instr     (instr),
        .rVal      (rVal),
        .halted    (halted)
    );

    task automatic fillMem(input logic [7:0] val);
        for (int k = 0; k < 16; k++) imem[k] = val;
    endtask

    task automatic applyStimulus(input logic rst, input logic run);
        reset  = rst;
        run_en = run;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset  = 1'b0;
        run_en = 1'b1;

        // MOV r1,r2 ; ADD r3,r1 ; MOV r0,r1 ; MOV r0,r3 ; HALT
        fillMem(8'hC0);
        imem[0] = 8'h0A; imem[1] = 8'h59; imem[2] = 8'h01; imem[3] = 8'h03;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_instr", 16'(instr), 16'h00);
        checkOutput("rst_rval", 16'(rVal), 16'h00);
        checkOutput("rst_addr", 16'(imem_addr), 16'h0);
        checkOutput("rst_halted", 16'(halted), 16'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("e0_instr", 16'(instr), 16'h0A);
        checkOutput("e0_addr", 16'(imem_addr), 16'h1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mov_rval", 16'(rVal), 16'h02);
        checkOutput("e1_instr", 16'(instr), 16'h59);
        applyStimulus(1'b1, 1'b1);
        checkOutput("add_fwd_rval", 16'(rVal), 16'h05);
        applyStimulus(1'b1, 1'b1);
        checkOutput("r1_readback", 16'(rVal), 16'h02);
        applyStimulus(1'b1, 1'b1);
        checkOutput("r3_readback", 16'(rVal), 16'h05);
        checkOutput("halt_at4", 16'(halted), 16'h1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("halt_rval0", 16'(rVal), 16'h00);

        // LDI r4,-1 ; ADD r4,r4 ; LDI r2,3 ; MOV r2,r4
        fillMem(8'hC0);
        imem[0] = 8'hA7; imem[1] = 8'h64; imem[2] = 8'h93; imem[3] = 8'h14;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ldi_neg", 16'(rVal), 16'hFF);
        applyStimulus(1'b1, 1'b1);
        checkOutput("add_wrap", 16'(rVal), 16'hFE);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ldi_pos", 16'(rVal), 16'h03);
        applyStimulus(1'b1, 1'b1);
        checkOutput("r4_readback", 16'(rVal), 16'hFE);

        // MOV r1,r2 ; HALT ; ADD r3,r1 (never executed)
        fillMem(8'h59);
        imem[0] = 8'h0A; imem[1] = 8'hC0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_halt", 16'(halted), 16'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("halt_set", 16'(halted), 16'h1);
        checkOutput("halt_addr", 16'(imem_addr), 16'h1);
        checkOutput("halt_instr", 16'(instr), 16'hC0);
        checkOutput("halt_drain", 16'(rVal), 16'h02);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("halted_rval", 16'(rVal), 16'h00);
            checkOutput("halted_instr", 16'(instr), 16'h00);
            checkOutput("halted_addr", 16'(imem_addr), 16'h1);
            checkOutput("halted_hold", 16'(halted), 16'h1);
        end

        // Freeze for three edges in the middle of the first program
        fillMem(8'hC0);
        imem[0] = 8'h0A; imem[1] = 8'h59; imem[2] = 8'h01; imem[3] = 8'h03;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("frz_addr", 16'(imem_addr), 16'h2);
            checkOutput("frz_instr", 16'(instr), 16'h59);
            checkOutput("frz_rval", 16'(rVal), 16'h02);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("thaw_add", 16'(rVal), 16'h05);
        applyStimulus(1'b1, 1'b1);
        checkOutput("thaw_r1", 16'(rVal), 16'h02);
        applyStimulus(1'b1, 1'b1);
        checkOutput("thaw_r3", 16'(rVal), 16'h05);

        // 16 MOVs with LDI r7,-1 at 3 and MOV r0,r7 at 4; PC wrap then mid-run reset
        for (int k = 0; k < 16; k++) imem[k] = 8'(k % 8);
        imem[3] = 8'hBF; imem[4] = 8'h07;
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("wrap_addr", 16'(imem_addr), 16'((k + 1) % 16));
            if (k == 4) checkOutput("ldi_r7", 16'(rVal), 16'hFF);
            if (k == 5) checkOutput("fwd_r7", 16'(rVal), 16'hFF);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("wrap_addr1", 16'(imem_addr), 16'h1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_rst_instr", 16'(instr), 16'h00);
        checkOutput("mid_rst_rval", 16'(rVal), 16'h00);
        checkOutput("mid_rst_addr", 16'(imem_addr), 16'h0);
        checkOutput("mid_rst_halted", 16'(halted), 16'h0);
        imem[0] = 8'h07;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("r7_restored", 16'(rVal), 16'h07);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
